fsm_ctrl_responder: RTL and testbench
=====================================

# fsm_ctrl_responder

Companion responder for the five-state control FSM. The control FSM emits a 4-bit control code per state (5, 8, 12, 14, 9 for S0..S4) and consumes a 2-bit steering input. This block sits on the other end of that link:
- decodes the incoming code and tracks how long the FSM has dwelt in each state;
- drives the 2-bit steering response to run the FSM through a programmed loop;
- checks every observed transition against the legal state graph;
- counts completed loops and errors.

## Interface
Parameters:
- HOLD_S1, 2: cycles the FSM is held in S1 (legal range 1..15).
- HOLD_S3, 3: cycles the FSM is held in S3 (legal range 1..15).
- SKIP_S3, 0: when 1, S2 is steered directly to S4.
- CNT_W, 8: width of the loop and error counters.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-low.
- enable  in  1  when 0, steer the FSM to park in S0.
- code_in  in  4  control code from the FSM.
- resp_out  out  2  steering response to the FSM's 2-bit input.
- obs_state  out  3  registered decoded state: 0..4, or 7 for none/invalid.
- code_err  out  1  one-cycle pulse when an unknown code is sampled.
- trans_err  out  1  one-cycle pulse when an illegal transition is sampled.
- loop_done  out  1  one-cycle pulse when an S4->S0 transition is sampled.
- loop_cnt  out  CNT_W  saturating count of loop_done events.
- err_cnt  out  CNT_W  saturating count of code_err plus trans_err events.

## Operation
- Decode: 5->S0, 8->S1, 12->S2, 14->S3, 9->S4. Every other code decodes to INV (7).
- Registers:
  - prev_q: decoded state from the previous cycle. Reset value 7.
  - run_q: 4-bit run length, saturates at 15. Reset value 0.
- Run length for the current cycle: run = (dec == prev_q && dec != INV) ? run_q+1 (saturating) : 1. On each clock edge, run_q <= run and prev_q <= dec.
- resp_out is combinational from code_in, run and enable:
  - enable=0: 00.
  - S0: 01.
  - S1: 01 if run < HOLD_S1, otherwise 00.
  - S2: 10 if SKIP_S3, otherwise 00.
  - S3: 11 if run < HOLD_S3, otherwise 00.
  - S4: 00.
  - INV: 00.
- Resulting FSM dwell: S1 lasts exactly HOLD_S1 cycles and S3 lasts exactly HOLD_S3 cycles.
- Legal transitions: S0->{S0,S1}, S1->{S1,S2}, S2->{S3,S4}, S3->{S3,S4}, S4->{S0}.
- Transition check:
  - Skipped when prev_q = 7.
  - An illegal transition between two valid states raises trans_err.
  - dec = INV raises code_err only. prev_q still updates to 7, so the next valid code is not checked.
- loop_done fires when prev_q = S4 and dec = S0.
- Counters: loop_cnt increments on loop_done. err_cnt increments by 1 when either error flag is set. Both counters saturate at all-ones.
- enable affects only resp_out. Decode, checking and counting always run.

## Timing
- resp_out: zero latency, combinational from code_in in the same cycle. No combinational loop exists, because the FSM's code depends only on its state register.
- obs_state, code_err, trans_err and loop_done are registered. They are valid in the cycle after the code is sampled, and each flag stays high for exactly one cycle.
- loop_cnt and err_cnt update on the same edge as their pulses.
- Reset (asynchronous, may assert mid-operation) clears:
  - obs_state to 7, prev_q to 7;
  - run_q, all pulses and both counters to 0.
- resp_out during reset depends only on code_in and enable, using run = 1.
- After reset release, the first sampled code is never flagged as a transition error.

## Configuration
- RESP_CHECK_EN defined: transition checker, code_err, trans_err and err_cnt are present as described above.
- RESP_CHECK_EN undefined:
  - code_err, trans_err and err_cnt are tied to 0, and the checking logic is removed.
  - Decode, resp_out, obs_state, loop_done and loop_cnt are unchanged.

## Test plan
- Closed loop with the control FSM, defaults, enable=1: code sequence 5,8,8,12,14,14,14,9 repeats with period 8. loop_done pulses every 8 cycles, loop_cnt increments, no errors.
- Closed loop, SKIP_S3=1: sequence 5,8,8,12,9 repeats with period 5. resp_out=10 during code 12.
- Closed loop, enable=0: resp_out=00, code stays 5, loop_cnt is unchanged. Raising enable gives code 8 on the next cycle.
- Open loop, drive code_in 5,12: trans_err pulses one cycle after 12 is sampled and err_cnt=1. Drive 3: code_err pulses, resp_out=00, obs_state=7.
- Reset asserted while in S3: outputs clear immediately. Release and drive 14: no trans_err is raised.
- CNT_W=2, run 4 loops: loop_cnt saturates at 3. Build without RESP_CHECK_EN and repeat the illegal sequence: no error pulses.

Source files
------------

// File: rtl/fsm_ctrl_responder.sv
// Responder for the five-state control FSM: decodes its code, steers it round a loop,
// counts loops. Define RESP_CHECK_EN to include the transition checker and error counter.
module fsm_ctrl_responder #(
  parameter int HOLD_S1 = 2,
  parameter int HOLD_S3 = 3,
  parameter int SKIP_S3 = 0,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [3:0]       code_in,
  output logic [1:0]       resp_out,
  output logic [2:0]       obs_state,
  output logic             code_err,
  output logic             trans_err,
  output logic             loop_done,
  output logic [CNT_W-1:0] loop_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [2:0] ST_S0  = 3'd0;
  localparam logic [2:0] ST_S1  = 3'd1;
  localparam logic [2:0] ST_S2  = 3'd2;
  localparam logic [2:0] ST_S3  = 3'd3;
  localparam logic [2:0] ST_S4  = 3'd4;
  localparam logic [2:0] ST_INV = 3'd7;

  localparam logic [3:0] HOLD1 = 4'(HOLD_S1);
  localparam logic [3:0] HOLD3 = 4'(HOLD_S3);

  logic [2:0]       dec;
  logic [3:0]       run;
  logic [2:0]       prev_q, prev_d;
  logic [3:0]       run_q, run_d;
  logic [2:0]       obs_q, obs_d;
  logic             loop_q, loop_d;
  logic [CNT_W-1:0] loop_cnt_q, loop_cnt_d;

  always_comb begin
    dec = ST_INV;
    case (code_in)
      4'd5:    dec = ST_S0;
      4'd8:    dec = ST_S1;
      4'd12:   dec = ST_S2;
      4'd14:   dec = ST_S3;
      4'd9:    dec = ST_S4;
      default: dec = ST_INV;
    endcase
  end

  // Dwell length including the current cycle; reset leaves prev_q at INV so run is 1.
  always_comb begin
    run = 4'd1;
    if (dec == prev_q && dec != ST_INV) begin
      run = (run_q == 4'hF) ? 4'hF : run_q + 4'd1;
    end
  end

  always_comb begin
    resp_out = 2'b00;
    if (enable) begin
      case (dec)
        ST_S0:   resp_out = 2'b01;
        ST_S1:   resp_out = (run < HOLD1) ? 2'b01 : 2'b00;
        ST_S2:   resp_out = (SKIP_S3 != 0) ? 2'b10 : 2'b00;
        ST_S3:   resp_out = (run < HOLD3) ? 2'b11 : 2'b00;
        default: resp_out = 2'b00;
      endcase
    end
  end

  always_comb begin
    prev_d     = dec;
    run_d      = run;
    obs_d      = dec;
    loop_d     = (prev_q == ST_S4) && (dec == ST_S0);
    loop_cnt_d = loop_cnt_q;
    if (loop_d && loop_cnt_q != {CNT_W{1'b1}}) begin
      loop_cnt_d = loop_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q     <= ST_INV;
      run_q      <= 4'd0;
      obs_q      <= ST_INV;
      loop_q     <= 1'b0;
      loop_cnt_q <= '0;
    end else begin
      prev_q     <= prev_d;
      run_q      <= run_d;
      obs_q      <= obs_d;
      loop_q     <= loop_d;
      loop_cnt_q <= loop_cnt_d;
    end
  end

  assign obs_state = obs_q;
  assign loop_done = loop_q;
  assign loop_cnt  = loop_cnt_q;

`ifdef RESP_CHECK_EN
  logic             legal;
  logic             code_err_q, code_err_d;
  logic             trans_err_q, trans_err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    legal = 1'b0;
    case (prev_q)
      ST_S0:   legal = (dec == ST_S0) || (dec == ST_S1);
      ST_S1:   legal = (dec == ST_S1) || (dec == ST_S2);
      ST_S2:   legal = (dec == ST_S3) || (dec == ST_S4);
      ST_S3:   legal = (dec == ST_S3) || (dec == ST_S4);
      ST_S4:   legal = (dec == ST_S0);
      default: legal = 1'b1;
    endcase
  end

  // An INV code is a code error only; the edge into or out of INV is never judged.
  always_comb begin
    code_err_d  = (dec == ST_INV);
    trans_err_d = (prev_q != ST_INV) && (dec != ST_INV) && !legal;
    err_cnt_d   = err_cnt_q;
    if ((code_err_d || trans_err_d) && err_cnt_q != {CNT_W{1'b1}}) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      code_err_q  <= 1'b0;
      trans_err_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      code_err_q  <= code_err_d;
      trans_err_q <= trans_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign code_err  = code_err_q;
  assign trans_err = trans_err_q;
  assign err_cnt   = err_cnt_q;
`else
  assign code_err  = 1'b0;
  assign trans_err = 1'b0;
  assign err_cnt   = '0;
`endif

endmodule

// File: tb/tb_fsm_ctrl_responder.sv
// Bench for fsm_ctrl_responder: two instances (defaults; skip/narrow counters) run closed loop
// against a control FSM model, then open loop with random codes, checked against a dwell model.
module tb_fsm_ctrl_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       enable;
  logic [3:0] code0, code1;
  logic [1:0] resp0, resp1;
  logic [2:0] obs0, obs1;
  logic       ce0, ce1, te0, te1, ld0, ld1;
  logic [7:0] lc0, ec0;
  logic [1:0] lc1, ec1;

  fsm_ctrl_responder #(.HOLD_S1(2), .HOLD_S3(3), .SKIP_S3(0), .CNT_W(8)) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .code_in(code0), .resp_out(resp0),
    .obs_state(obs0), .code_err(ce0), .trans_err(te0), .loop_done(ld0),
    .loop_cnt(lc0), .err_cnt(ec0));

  fsm_ctrl_responder #(.HOLD_S1(2), .HOLD_S3(1), .SKIP_S3(1), .CNT_W(2)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .code_in(code1), .resp_out(resp1),
    .obs_state(obs1), .code_err(ce1), .trans_err(te1), .loop_done(ld1),
    .loop_cnt(lc1), .err_cnt(ec1));

`ifdef RESP_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model per instance: last decoded state, dwell length, expected registered outputs.
  int m_last[2], m_run[2], m_obs[2], m_ce[2], m_te[2], m_ld[2], m_lc[2], m_ec[2];
  int fsm[2];
  int rs[2];

  function automatic int hs1(int k); return 2; endfunction
  function automatic int hs3(int k); return (k == 0) ? 3 : 1; endfunction
  function automatic int skp(int k); return k; endfunction
  function automatic int cmax(int k); return (k == 0) ? 255 : 3; endfunction

  function automatic int decode(int c);
    case (c)
      5: return 0;
      8: return 1;
      12: return 2;
      14: return 3;
      9: return 4;
      default: return 7;
    endcase
  endfunction

  function automatic int code_of(int s);
    case (s)
      0: return 5;
      1: return 8;
      2: return 12;
      3: return 14;
      default: return 9;
    endcase
  endfunction

  function automatic bit legal(int a, int b);
    case (a)
      0: return b == 0 || b == 1;
      1: return b == 1 || b == 2;
      2: return b == 3 || b == 4;
      3: return b == 3 || b == 4;
      default: return b == 0;
    endcase
  endfunction

  function automatic int run_of(int k, int c);
    int d = decode(c);
    if (d == m_last[k] && d != 7) return (m_run[k] >= 15) ? 15 : m_run[k] + 1;
    return 1;
  endfunction

  function automatic int exp_resp(int k, int c);
    int d = decode(c);
    int r = run_of(k, c);
    if (!enable) return 0;
    case (d)
      0: return 1;
      1: return (r < hs1(k)) ? 1 : 0;
      2: return (skp(k) != 0) ? 2 : 0;
      3: return (r < hs3(k)) ? 3 : 0;
      default: return 0;
    endcase
  endfunction

  // Control FSM seen from the other side of the link.
  function automatic int fsm_next(int s, int r);
    case (s)
      0: return (r == 1) ? 1 : 0;
      1: return (r == 1) ? 1 : 2;
      2: return (r == 2) ? 4 : 3;
      3: return (r == 3) ? 3 : 4;
      default: return 0;
    endcase
  endfunction

  function automatic int code_k(int k);
    return (k == 0) ? int'(code0) : int'(code1);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_last[k] = 7; m_run[k] = 0; m_obs[k] = 7;
      m_ce[k] = 0; m_te[k] = 0; m_ld[k] = 0; m_lc[k] = 0; m_ec[k] = 0;
      fsm[k] = 0;
    end
  endtask

  task automatic model_clock();
    for (int k = 0; k < 2; k++) begin
      int c = code_k(k);
      int d = decode(c);
      int r = run_of(k, c);
      m_ce[k] = (CHK && d == 7) ? 1 : 0;
      m_te[k] = (CHK && m_last[k] != 7 && d != 7 && !legal(m_last[k], d)) ? 1 : 0;
      m_ld[k] = (m_last[k] == 4 && d == 0) ? 1 : 0;
      if (m_ld[k] == 1 && m_lc[k] < cmax(k)) m_lc[k]++;
      if ((m_ce[k] == 1 || m_te[k] == 1) && m_ec[k] < cmax(k)) m_ec[k]++;
      m_obs[k] = d;
      m_run[k] = r;
      m_last[k] = d;
    end
  endtask

  task automatic check_regs();
    check("obs0", obs0, m_obs[0]);   check("obs1", obs1, m_obs[1]);
    check("code_err0", ce0, m_ce[0]); check("code_err1", ce1, m_ce[1]);
    check("trans_err0", te0, m_te[0]); check("trans_err1", te1, m_te[1]);
    check("loop_done0", ld0, m_ld[0]); check("loop_done1", ld1, m_ld[1]);
    check("loop_cnt0", lc0, m_lc[0]); check("loop_cnt1", lc1, m_lc[1]);
    check("err_cnt0", ec0, m_ec[0]); check("err_cnt1", ec1, m_ec[1]);
  endtask

  // One cycle: drive at negedge, check resp, sample on posedge, check registers at next negedge.
  task automatic tick(input bit closed, input int oc0, input int oc1);
    if (closed) begin
      code0 = 4'(code_of(fsm[0]));
      code1 = 4'(code_of(fsm[1]));
    end else begin
      code0 = oc0[3:0];
      code1 = oc1[3:0];
    end
    #1;
    check("resp0", resp0, exp_resp(0, code0));
    check("resp1", resp1, exp_resp(1, code1));
    rs[0] = resp0;
    rs[1] = resp1;
    @(posedge clk);
    if (reset) begin
      model_clock();
      if (closed) begin
        fsm[0] = fsm_next(fsm[0], rs[0]);
        fsm[1] = fsm_next(fsm[1], rs[1]);
      end
    end
    @(negedge clk);
    check_regs();
  endtask

  int exp_seq0[8] = '{5, 8, 8, 12, 14, 14, 14, 9};
  int exp_seq1[5] = '{5, 8, 8, 12, 9};
  int seq0[8], seq1[5];
  int resp1_at12;
  int vcodes[5] = '{5, 8, 12, 14, 9};

  initial begin
    int n;
    int p0, p1;
    reset = 1'b0;
    enable = 1'b1;
    code0 = 4'd5;
    code1 = 4'd5;
    model_reset();
    @(negedge clk);
    #1;
    check_regs();
    @(negedge clk);
    reset = 1'b1;

    // Closed loop from reset: record opening code sequences and loop counts.
    resp1_at12 = -1;
    for (int i = 0; i < 40; i++) begin
      if (i < 8) seq0[i] = fsm[0] == 0 ? 5 : code_of(fsm[0]);
      if (i < 5) seq1[i] = code_of(fsm[1]);
      tick(1'b1, 0, 0);
      if (i == 3) resp1_at12 = rs[1];
    end
    for (int i = 0; i < 8; i++) check($sformatf("seq0[%0d]", i), seq0[i], exp_seq0[i]);
    for (int i = 0; i < 5; i++) check($sformatf("seq1[%0d]", i), seq1[i], exp_seq1[i]);
    check("resp1 during code 12", resp1_at12, 2);
    check("loop_cnt0 after 40", lc0, 4);
    check("loop_cnt1 saturated", lc1, 3);

    // Park with enable low, then release.
    enable = 1'b0;
    for (int i = 0; i < 12; i++) tick(1'b1, 0, 0);
    check("parked code0", code0, 5);
    check("parked resp0", resp0, 0);
    enable = 1'b1;
    tick(1'b1, 0, 0);
    tick(1'b1, 0, 0);
    check("code0 after enable", code0, 8);

    // Open loop: illegal S0->S2 then an unknown code.
    tick(1'b0, 5, 5);
    tick(1'b0, 12, 12);
    check("trans_err on 5,12", te0, CHK ? 1 : 0);
    tick(1'b0, 3, 3);
    check("code_err on 3", ce0, CHK ? 1 : 0);
    check("obs on 3", obs0, 7);
    check("resp on 3", resp0, 0);

    // Random open loop: favour repeats so dwell limits and saturation are exercised.
    p0 = 5; p1 = 5;
    for (int i = 0; i < 300; i++) begin
      n = $urandom_range(0, 9);
      if (n >= 5) begin
        p0 = (n == 9) ? int'($urandom_range(0, 15)) : vcodes[$urandom_range(0, 4)];
      end
      n = $urandom_range(0, 9);
      if (n >= 5) begin
        p1 = (n == 9) ? int'($urandom_range(0, 15)) : vcodes[$urandom_range(0, 4)];
      end
      enable = ($urandom_range(0, 7) != 0);
      tick(1'b0, p0, p1);
    end
    enable = 1'b1;

    // Asynchronous reset while the FSM sits in S3.
    reset = 1'b0;
    @(negedge clk);
    model_reset();
    reset = 1'b1;
    n = 0;
    while (fsm[0] != 3 && n < 20) begin
      tick(1'b1, 0, 0);
      n++;
    end
    check("reached S3", fsm[0], 3);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_regs();
    check("resp0 in reset", resp0, exp_resp(0, code0));
    @(negedge clk);
    reset = 1'b1;
    tick(1'b0, 14, 14);
    check("no trans_err after reset", te0, 0);
    check("obs after reset", obs0, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
